// File: rtl/vnu_pkg.sv
// vnu_pkg: shared types and defaults for the VNU iteration/group scheduler.
//   vnu_state_t   - scheduler FSM states
//   *_DEF         - default geometry of the shuffled VNU datapath
//   grp_addr_t    - group address for the default geometry
//   clog2_min1()  - address/counter width helper that never returns 0
package vnu_pkg;

  localparam int N_GROUPS_DEF = 16;
  localparam int MAX_ITER_DEF = 8;
  localparam int PIPE_LAT_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } vnu_state_t;

  // Width for a counter holding 0..v-1; a single group/iteration still needs a bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  localparam int GRP_ADDR_W_DEF = clog2_min1(N_GROUPS_DEF);

  typedef logic [GRP_ADDR_W_DEF-1:0] grp_addr_t;

endpackage

// File: rtl/vnu_dly_line.sv
// vnu_dly_line: enable-gated shift register carrying {valid, addr} from the
// read-issue point to the write-back point of the VNU pipeline.
//   clk      - clock
//   clr_n    - synchronous active-low clear (empties every stage)
//   en       - shift enable; when low every stage holds
//   in_vld   - valid bit entering stage 0
//   in_addr  - group address entering stage 0
//   out_vld  - valid bit leaving the last stage
//   out_addr - group address leaving the last stage
module vnu_dly_line #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  input  logic         in_vld,
  input  logic [W-1:0] in_addr,
  output logic         out_vld,
  output logic [W-1:0] out_addr
);

  logic [DEPTH-1:0]        vld_pipe;
  logic [DEPTH-1:0][W-1:0] addr_pipe;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else if (en) begin
      vld_pipe[0]  <= in_vld;
      addr_pipe[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  assign out_vld  = vld_pipe[DEPTH-1];
  assign out_addr = addr_pipe[DEPTH-1];

endmodule

// File: rtl/vnu_sched.sv
// vnu_sched: iteration and column-group scheduler for the shuffled VNU datapath.
// Each iteration issues one group read per unstalled cycle, waits for the VNU
// pipeline to write every group back, then checks parity to either start the
// next iteration or finish the codeword.
//   i_clk, i_rst_n  - clock, synchronous active-low reset
//   i_start         - start one codeword (IDLE only)
//   i_stall         - freezes read issue and the write-back delay line
//   i_parity_ok     - all checks satisfied (looked at in CHECK only)
//   o_busy          - not IDLE
//   o_rd_en/addr    - message RAM read strobe / group
//   o_first_iter    - iteration 0 in progress (channel LLRs only)
//   o_wr_en/addr    - write-back strobe / group
//   o_iter          - current iteration index
//   o_done          - one-cycle end-of-decode pulse
//   o_converged     - parity satisfied at termination, held until next start
module vnu_sched
  import vnu_pkg::*;
#(
  parameter int N_GROUPS = N_GROUPS_DEF,
  parameter int MAX_ITER = MAX_ITER_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF,
  parameter int ADDR_W   = clog2_min1(N_GROUPS),
  parameter int ITER_W   = clog2_min1(MAX_ITER)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_stall,
  input  logic              i_parity_ok,
  output logic              o_busy,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_first_iter,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [ITER_W-1:0] o_iter,
  output logic              o_done,
  output logic              o_converged
);

  localparam int CNT_W = clog2_min1(PIPE_LAT);

  localparam logic [ADDR_W-1:0] LAST_GRP  = ADDR_W'(N_GROUPS - 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(MAX_ITER - 1);
  localparam logic [CNT_W-1:0]  LAST_DRN  = CNT_W'(PIPE_LAT - 1);

  vnu_state_t        state, state_nxt;
  logic [ADDR_W-1:0] grp, grp_nxt;
  logic [ITER_W-1:0] iter, iter_nxt;
  logic [CNT_W-1:0]  drn_cnt, drn_cnt_nxt;
  logic              conv, conv_nxt;

  logic              issue;
  logic              wb_vld;
  logic [ADDR_W-1:0] wb_addr;

  // A read goes out on every unstalled READ cycle.
  assign issue = (state == ST_READ) && !i_stall;

  always_comb begin
    state_nxt   = state;
    grp_nxt     = grp;
    iter_nxt    = iter;
    drn_cnt_nxt = drn_cnt;
    conv_nxt    = conv;
    unique case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt = ST_READ;
          grp_nxt   = '0;
          iter_nxt  = '0;
          conv_nxt  = 1'b0;
        end
      end
      ST_READ: begin
        if (!i_stall) begin
          if (grp == LAST_GRP) begin
            state_nxt   = ST_DRAIN;
            grp_nxt     = '0;
            drn_cnt_nxt = '0;
          end else begin
            grp_nxt = grp + ADDR_W'(1);
          end
        end
      end
      // Counts unstalled cycles only, so it stays aligned with the delay
      // line: the last write-back lands in the final DRAIN cycle.
      ST_DRAIN: begin
        if (!i_stall) begin
          if (drn_cnt == LAST_DRN) begin
            state_nxt   = ST_CHECK;
            drn_cnt_nxt = '0;
          end else begin
            drn_cnt_nxt = drn_cnt + CNT_W'(1);
          end
        end
      end
      // Stall is deliberately not looked at: the pipeline is empty here.
      ST_CHECK: begin
        if (i_parity_ok) begin
          conv_nxt  = 1'b1;
          state_nxt = ST_DONE;
        end else if (iter == LAST_ITER) begin
          state_nxt = ST_DONE;
        end else begin
          iter_nxt  = iter + ITER_W'(1);
          grp_nxt   = '0;
          state_nxt = ST_READ;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      grp     <= '0;
      iter    <= '0;
      drn_cnt <= '0;
      conv    <= 1'b0;
    end else begin
      state   <= state_nxt;
      grp     <= grp_nxt;
      iter    <= iter_nxt;
      drn_cnt <= drn_cnt_nxt;
      conv    <= conv_nxt;
    end
  end

  // Reset also empties the line, so writes still in flight are dropped.
  vnu_dly_line #(
    .DEPTH (PIPE_LAT),
    .W     (ADDR_W)
  ) u_wb_dly (
    .clk      (i_clk),
    .clr_n    (i_rst_n),
    .en       (!i_stall),
    .in_vld   (issue),
    .in_addr  (grp),
    .out_vld  (wb_vld),
    .out_addr (wb_addr)
  );

  assign o_busy       = (state != ST_IDLE);
  assign o_rd_en      = issue;
  assign o_rd_addr    = grp;
  assign o_first_iter = (iter == '0) && o_busy;
  // A stalled cycle holds the line, so the same entry must not write twice.
  assign o_wr_en      = wb_vld && !i_stall;
  assign o_wr_addr    = wb_addr;
  assign o_iter       = iter;
  assign o_done       = (state == ST_DONE);
  assign o_converged  = conv;

endmodule

// File: tb/tb_vnu_sched.sv
// tb_vnu_sched: randomized scoreboard bench for vnu_sched (default geometry)
// plus a directed run of the single-group, single-iteration configuration.
module tb_vnu_sched;

  localparam int N = 16;
  localparam int L = 4;
  localparam int M = 8;

  typedef struct { int cyc; int addr; } ev_t;
  typedef struct { int cyc; int iter; int conv; } done_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_start = 1'b0, a_stall = 1'b0, a_par = 1'b0;
  logic a_busy, a_rd_en, a_first, a_wr_en, a_done, a_conv;
  logic [3:0] a_rd_addr, a_wr_addr;
  logic [2:0] a_iter;

  logic b_start = 1'b0, b_stall = 1'b0, b_par = 1'b0;
  logic b_busy, b_rd_en, b_first, b_wr_en, b_done, b_conv;
  logic [0:0] b_rd_addr, b_wr_addr, b_iter;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  bit exp_busy = 1'b0, exp_first = 1'b0;
  int exp_iter = 0;
  int exp_conv = 0;

  ev_t   rdq[$];
  ev_t   wrq[$];
  done_t doneq[$];

  vnu_sched u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .i_stall(a_stall),
    .i_parity_ok(a_par), .o_busy(a_busy), .o_rd_en(a_rd_en),
    .o_rd_addr(a_rd_addr), .o_first_iter(a_first), .o_wr_en(a_wr_en),
    .o_wr_addr(a_wr_addr), .o_iter(a_iter), .o_done(a_done),
    .o_converged(a_conv)
  );

  vnu_sched #(.N_GROUPS(1), .MAX_ITER(1), .PIPE_LAT(1)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_stall(b_stall),
    .i_parity_ok(b_par), .o_busy(b_busy), .o_rd_en(b_rd_en),
    .o_rd_addr(b_rd_addr), .o_first_iter(b_first), .o_wr_en(b_wr_en),
    .o_wr_addr(b_wr_addr), .o_iter(b_iter), .o_done(b_done),
    .o_converged(b_conv)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void unexpected(input string nm, input int addr);
    n_tests++;
    n_fail++;
    $display("FAIL %s: strobe with addr %0d but none expected (cycle %0d)", nm, addr, cyc);
  endfunction

  // Monitor: per-cycle status checks plus scoreboard pops on each strobe.
  always @(negedge clk) begin
    if (mon_en) begin
      ev_t e;
      done_t d;
      chk("busy", int'(a_busy), int'(exp_busy));
      chk("first_iter", int'(a_first), int'(exp_first));
      chk("converged", int'(a_conv), exp_conv);
      if (exp_busy) chk("iter", int'(a_iter), exp_iter);
      if (a_rd_en) begin
        if (rdq.size() == 0) unexpected("rd_unexpected", int'(a_rd_addr));
        else begin
          e = rdq.pop_front();
          chk("rd_cycle", cyc, e.cyc);
          chk("rd_addr", int'(a_rd_addr), e.addr);
        end
      end
      if (a_wr_en) begin
        if (wrq.size() == 0) unexpected("wr_unexpected", int'(a_wr_addr));
        else begin
          e = wrq.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr", int'(a_wr_addr), e.addr);
        end
      end
      if (a_done) begin
        if (doneq.size() == 0) unexpected("done_unexpected", int'(a_iter));
        else begin
          d = doneq.pop_front();
          chk("done_cycle", cyc, d.cyc);
          chk("done_iter", int'(a_iter), d.iter);
          chk("done_converged", int'(a_conv), d.conv);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic st, input logic stl, input logic par, input logic rn);
    tick();
    a_start = st;
    a_stall = stl;
    a_par   = par;
    rst_n   = rn;
  endtask

  function automatic logic pick_stall(input int mode, input int rel);
    case (mode)
      1:       return (rel >= 7 && rel <= 9);
      2:       return ($urandom_range(0, 3) == 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      a_drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      exp_busy  = 1'b0;
      exp_first = 1'b0;
    end
  endtask

  // One codeword. Model: an iteration is N+L unstalled cycles followed by one
  // CHECK cycle; the k-th unstalled cycle reads group k-1 and writes group
  // k-1-L. plan[j] is the parity answer given at the CHECK of iteration j.
  // rst_iter >= 0 pulls reset in a DRAIN cycle of that iteration.
  task automatic run(input int mode, input logic [7:0] plan, input int rst_iter);
    int  s, j, u;
    bit  fin, rst, stl, stt;
    int  conv_res;
    stt = (mode != 0) && ($urandom_range(0, 5) == 0);
    a_drive(1'b1, pick_stall(mode, 0), 1'($urandom_range(0, 1)), 1'b1);
    s = cyc;
    exp_busy  = 1'b0;
    exp_first = 1'b0;
    j = 0;
    fin = 1'b0;
    conv_res = 0;
    while (!fin) begin
      u = 0;
      while (u < N + L) begin
        rst = (j == rst_iter) && (u == N + 1);
        stl = rst ? 1'b0 : pick_stall(mode, cyc + 1 - s);
        stt = (mode != 0) && ($urandom_range(0, 5) == 0);
        a_drive(stt, stl, 1'($urandom_range(0, 1)), !rst);
        exp_busy  = 1'b1;
        exp_iter  = j;
        exp_first = (j == 0);
        exp_conv  = 0;
        if (!stl) begin
          u++;
          if (u <= N) rdq.push_back('{cyc, u - 1});
          if (u > L)  wrq.push_back('{cyc, u - 1 - L});
        end
        if (rst) begin
          a_drive(1'b0, 1'b0, 1'b0, 1'b1);
          exp_busy  = 1'b0;
          exp_first = 1'b0;
          exp_conv  = 0;
          #1;
          chk("rst_busy", int'(a_busy), 0);
          chk("rst_rd_en", int'(a_rd_en), 0);
          chk("rst_rd_addr", int'(a_rd_addr), 0);
          chk("rst_wr_en", int'(a_wr_en), 0);
          chk("rst_wr_addr", int'(a_wr_addr), 0);
          chk("rst_iter", int'(a_iter), 0);
          chk("rst_done", int'(a_done), 0);
          chk("rst_first", int'(a_first), 0);
          return;
        end
      end
      // CHECK cycle: stall is irrelevant, parity decides.
      a_drive(stt, pick_stall(mode, cyc + 1 - s), plan[j], 1'b1);
      exp_busy  = 1'b1;
      exp_iter  = j;
      exp_first = (j == 0);
      exp_conv  = 0;
      if (plan[j] || j == M - 1) begin
        conv_res = int'(plan[j]);
        doneq.push_back('{cyc + 1, j, conv_res});
        fin = 1'b1;
      end else begin
        j++;
      end
    end
    a_drive(stt, pick_stall(mode, cyc + 1 - s), 1'($urandom_range(0, 1)), 1'b1);
    exp_busy  = 1'b1;
    exp_iter  = j;
    exp_first = (j == 0);
    exp_conv  = conv_res;
  endtask

  task automatic b_run(input logic par, input logic stall1);
    tick(); b_start = 1'b1; b_stall = 1'b0; b_par = 1'b0;
    tick(); b_start = 1'b0; b_stall = stall1; #1;
    if (stall1) begin
      chk("b_stall_rd_en", int'(b_rd_en), 0);
      chk("b_stall_busy", int'(b_busy), 1);
      tick(); b_stall = 1'b0; #1;
    end
    chk("b_rd_en", int'(b_rd_en), 1);
    chk("b_rd_addr", int'(b_rd_addr), 0);
    chk("b_first", int'(b_first), 1);
    chk("b_wr_en_early", int'(b_wr_en), 0);
    tick(); b_par = !par; #1;
    chk("b_wr_en", int'(b_wr_en), 1);
    chk("b_wr_addr", int'(b_wr_addr), 0);
    chk("b_rd_en_drain", int'(b_rd_en), 0);
    tick(); b_par = par; b_stall = 1'b1; #1;
    chk("b_check_busy", int'(b_busy), 1);
    chk("b_check_strobes", int'(b_rd_en) + int'(b_wr_en) + int'(b_done), 0);
    tick(); b_par = 1'b0; b_stall = 1'b0; #1;
    chk("b_done", int'(b_done), 1);
    chk("b_done_conv", int'(b_conv), int'(par));
    chk("b_done_iter", int'(b_iter), 0);
    tick(); #1;
    chk("b_idle_busy", int'(b_busy), 0);
    chk("b_idle_done", int'(b_done), 0);
    chk("b_idle_conv", int'(b_conv), int'(par));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] plan;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_busy", int'(a_busy), 0);
    chk("reset_rd_en", int'(a_rd_en), 0);
    chk("reset_wr_en", int'(a_wr_en), 0);
    chk("reset_done", int'(a_done), 0);
    chk("reset_conv", int'(a_conv), 0);
    chk("reset_iter", int'(a_iter), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(2);

    run(0, 8'h01, -1); idle(3);   // converge at first CHECK
    run(0, 8'h00, -1); idle(3);   // never converges: MAX_ITER iterations
    run(1, 8'h01, -1); idle(3);   // 3-cycle stall after the addr-5 read
    run(0, 8'h00, 2);  idle(2);   // reset during DRAIN of iteration 2
    run(0, 8'h02, -1); idle(2);   // clean restart after reset
    repeat (6) begin
      plan = '0;
      for (int i = 0; i < 8; i++) plan[i] = ($urandom_range(0, 3) == 0);
      run(2, plan, -1);
      idle($urandom_range(1, 4));
    end
    idle(3);
    chk("rd_queue_left", rdq.size(), 0);
    chk("wr_queue_left", wrq.size(), 0);
    chk("done_queue_left", doneq.size(), 0);

    b_run(1'b1, 1'b0);
    tick();
    b_run(1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
